// File: rtl/control_sequencer.sv
// control_sequencer: fetch/execute control FSM decoding 9-bit instructions into datapath and fetch controls
// Ports: clk/reset (async, active-high); _instruction/insnValid/insnReady form the fetch handshake;
// compareFlag gates branches; memDone completes LD/SV; halt/branch/jump/relative/destBranchJump drive fetch;
// regA/regB/regWrite/muxRI/muxMA/overflowWrite/compareWrite/memoryRead/memoryWrite/immediateValue/funcCode
// drive the datapath; memError is a sticky memory-timeout flag.
module control_sequencer #(
  parameter int INSN_WIDTH  = 9,
  parameter int DATA_WIDTH  = 8,
  parameter int REG_WIDTH   = 2,
  parameter int FUNC_WIDTH  = 3,
  parameter int FLAG_WIDTH  = 2,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [INSN_WIDTH-1:0] _instruction,
  input  logic                  insnValid,
  output logic                  insnReady,
  input  logic                  compareFlag,
  input  logic                  memDone,
  output logic                  halt,
  output logic                  branch,
  output logic                  jump,
  output logic                  relative,
  output logic [DATA_WIDTH-1:0] destBranchJump,
  output logic [REG_WIDTH-1:0]  regA,
  output logic [REG_WIDTH-1:0]  regB,
  output logic                  regWrite,
  output logic                  muxRI,
  output logic                  muxMA,
  output logic                  overflowWrite,
  output logic                  compareWrite,
  output logic                  memoryRead,
  output logic                  memoryWrite,
  output logic [DATA_WIDTH-1:0] immediateValue,
  output logic [FUNC_WIDTH-1:0] funcCode,
  output logic                  memError
);
  localparam logic [1:0] IDLE = 2'd0, EXEC = 2'd1, MEM_WAIT = 2'd2, HALTED = 2'd3;
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  logic [1:0]            r_state;
  logic [INSN_WIDTH-1:0] r_insn;
  logic [CW-1:0]         r_cnt;
  logic                  r_mem_error;
  logic [FLAG_WIDTH-1:0] w_flags;
  logic [FUNC_WIDTH-1:0] w_func;
  logic w_halt_insn, w_set, w_bj, w_op, w_ld, w_sv, w_cmp, w_alu;
  logic w_exec, w_wait, w_timeout, w_regs, w_opx;
  logic [1:0] w_next;
  assign w_flags     = r_insn[INSN_WIDTH-1 -: FLAG_WIDTH];
  assign w_func      = r_insn[FUNC_WIDTH-1:0];
  assign w_halt_insn = &r_insn;
  assign w_set       = w_flags == FLAG_WIDTH'(0);
  assign w_bj        = w_flags == FLAG_WIDTH'(1);
  assign w_op        = w_flags == FLAG_WIDTH'(2);
  assign w_ld        = w_op && w_func == FUNC_WIDTH'(3);
  assign w_sv        = w_op && w_func == FUNC_WIDTH'(4);
  assign w_cmp       = w_op && w_func >= FUNC_WIDTH'(5);
  assign w_alu       = w_op && !w_ld && !w_sv && !w_cmp;
  assign w_exec      = r_state == EXEC;
  assign w_wait      = r_state == MEM_WAIT;
  // memDone in the final wait cycle takes priority over the timeout
  assign w_timeout   = w_wait && !memDone && r_cnt == CW'(MEM_TIMEOUT - 1);
  assign w_next = r_state == IDLE ? (insnValid ? EXEC : IDLE)
                : w_exec ? (w_halt_insn ? HALTED : (w_ld || w_sv) ? MEM_WAIT : IDLE)
                : w_wait ? ((memDone || w_timeout) ? IDLE : MEM_WAIT)
                : HALTED;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_insn      <= '0;
      r_cnt       <= '0;
      r_mem_error <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_wait && !memDone) ? r_cnt + 1'b1 : '0;
      if (r_state == IDLE && insnValid) r_insn <= _instruction;
      if (w_timeout) r_mem_error <= 1'b1;
    end
  end
  // MEM_WAIT is only reachable from LD/SV, so it always carries operation fields
  assign w_regs = (w_exec && (w_set || w_op)) || w_wait;
  assign w_opx  = (w_exec || w_wait) && w_op;
  assign insnReady      = r_state == IDLE && !reset;
  assign halt           = r_state == HALTED || (w_exec && w_halt_insn);
  assign branch         = w_exec && w_bj && !r_insn[6] && compareFlag;
  assign jump           = w_exec && w_bj && r_insn[6];
  assign relative       = w_exec && w_bj && r_insn[5];
  assign destBranchJump = (w_exec && w_bj) ? {{(DATA_WIDTH-5){r_insn[5] & r_insn[4]}}, r_insn[4:0]} : '0;
  assign regA           = w_regs ? r_insn[6:5] : '0;
  assign regB           = (w_exec && w_op) || w_wait ? r_insn[4:3] : '0;
  assign funcCode       = w_opx ? w_func : '0;
  assign regWrite       = (w_exec && (w_set || w_alu)) || (w_wait && w_ld && memDone);
  assign muxRI          = w_exec && w_set;
  assign muxMA          = w_exec && (w_set || w_alu);
  assign overflowWrite  = w_exec && w_alu;
  assign compareWrite   = w_exec && w_cmp;
  assign memoryRead     = w_opx && w_ld;
  assign memoryWrite    = w_opx && w_sv;
  assign immediateValue = (w_exec && w_set) ? {{(DATA_WIDTH-5){1'b0}}, r_insn[4:0]} : '0;
  assign memError       = r_mem_error;
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed and randomized checks of control_sequencer against an instruction-level model
module tb_control_sequencer;
  logic clk = 1'b0, reset = 1'b1, insnValid = 1'b0, compareFlag = 1'b0, memDone = 1'b0;
  logic [8:0] _instruction = '0;
  logic insnReady, halt, branch, jump, relative, regWrite, muxRI, muxMA, overflowWrite;
  logic compareWrite, memoryRead, memoryWrite, memError;
  logic [7:0] destBranchJump, immediateValue;
  logic [1:0] regA, regB;
  logic [2:0] funcCode;
  int n_vec = 0, n_err = 0;
  bit me = 1'b0;
  localparam int P_RST = 0, P_IDLE = 1, P_EXEC = 2, P_WAIT = 3, P_HALT = 4;
  typedef struct packed {
    logic halt, branch, jump, relative;
    logic [7:0] dest;
    logic [1:0] ra, rb;
    logic rw, ri, ma, ow, cw, mr, mw;
    logic [7:0] imm;
    logic [2:0] fc;
    logic me, rdy;
  } outs_t;
  control_sequencer dut (
    .clk(clk), .reset(reset), ._instruction(_instruction), .insnValid(insnValid),
    .insnReady(insnReady), .compareFlag(compareFlag), .memDone(memDone), .halt(halt),
    .branch(branch), .jump(jump), .relative(relative), .destBranchJump(destBranchJump),
    .regA(regA), .regB(regB), .regWrite(regWrite), .muxRI(muxRI), .muxMA(muxMA),
    .overflowWrite(overflowWrite), .compareWrite(compareWrite), .memoryRead(memoryRead),
    .memoryWrite(memoryWrite), .immediateValue(immediateValue), .funcCode(funcCode),
    .memError(memError)
  );
  always #5 clk = ~clk;
  function automatic outs_t sample();
    return {halt, branch, jump, relative, destBranchJump, regA, regB, regWrite, muxRI, muxMA,
            overflowWrite, compareWrite, memoryRead, memoryWrite, immediateValue, funcCode,
            memError, insnReady};
  endfunction
  function automatic outs_t ref_out(int ph, int insn, bit cf, bit md, bit err);
    outs_t o = '0;
    int kind = insn / 128, f = insn % 8, lo = insn % 32;
    if (ph == P_RST) return o;
    o.me = err;
    if (ph == P_IDLE) o.rdy = 1'b1;
    else if (ph == P_HALT) o.halt = 1'b1;
    else if (ph == P_WAIT) begin
      o.ra = 2'((insn / 32) % 4);
      o.rb = 2'((insn / 8) % 4);
      o.fc = 3'(f);
      o.mr = f == 3;
      o.mw = f == 4;
      o.rw = f == 3 && md;
    end else if (kind == 0) begin
      o.ra = 2'((insn / 32) % 4);
      o.imm = 8'(lo);
      o.rw = 1'b1;
      o.ri = 1'b1;
      o.ma = 1'b1;
    end else if (kind == 1) begin
      o.jump = (insn / 64) % 2 == 1;
      o.branch = (insn / 64) % 2 == 0 && cf;
      o.relative = (insn / 32) % 2 == 1;
      o.dest = 8'((o.relative && lo >= 16) ? lo + 224 : lo);
    end else if (kind == 2) begin
      o.ra = 2'((insn / 32) % 4);
      o.rb = 2'((insn / 8) % 4);
      o.fc = 3'(f);
      o.cw = f >= 5;
      o.mr = f == 3;
      o.mw = f == 4;
      o.rw = f < 3;
      o.ma = f < 3;
      o.ow = f < 3;
    end else o.halt = insn == 511;
    return o;
  endfunction
  task automatic check(string tag, outs_t exp);
    outs_t obs = sample();
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_hold();
    insnValid = 1'b0;
    _instruction = 9'($urandom);
    #1 check("idle_novalid", ref_out(P_IDLE, 0, 0, 0, me));
    tick();
    #1 check("idle_stay", ref_out(P_IDLE, 0, 0, 0, me));
  endtask
  task automatic run_insn(string tag, int insn, bit cf, int d);
    bit done;
    _instruction = 9'(insn);
    insnValid = 1'b1;
    compareFlag = cf;
    memDone = 1'b0;
    #2 check({tag, "_idle"}, ref_out(P_IDLE, insn, cf, 0, me));
    tick();
    _instruction = 9'($urandom);
    insnValid = 1'($urandom);
    #1 check({tag, "_exec"}, ref_out(P_EXEC, insn, cf, 0, me));
    if (insn == 511) begin
      for (int i = 0; i < 4; i++) begin
        tick();
        insnValid = 1'b1;
        compareFlag = 1'($urandom);
        memDone = 1'($urandom);
        _instruction = 9'($urandom);
        #1 check({tag, "_halted"}, ref_out(P_HALT, insn, cf, 0, me));
      end
      return;
    end
    if (insn / 128 == 2 && (insn % 8 == 3 || insn % 8 == 4)) begin
      tick();
      for (int k = 0; k < 15; k++) begin
        memDone = k == d;
        compareFlag = 1'($urandom);
        _instruction = 9'($urandom);
        #1 check({tag, "_wait"}, ref_out(P_WAIT, insn, cf, memDone, me));
        done = memDone || k == 14;
        if (k == 14 && !memDone) me = 1'b1;
        tick();
        if (done) break;
      end
      memDone = 1'b0;
    end else tick();
    insnValid = 1'b0;
  endtask
  task automatic do_reset();
    #2 reset = 1'b1;
    #1 check("reset_assert", ref_out(P_RST, 0, 0, 0, 0));
    tick();
    reset = 1'b0;
    me = 1'b0;
    #1 check("reset_release", ref_out(P_IDLE, 0, 0, 0, me));
  endtask
  initial begin
    #2 check("por", ref_out(P_RST, 0, 0, 0, 0));
    tick();
    reset = 1'b0;
    #1 check("post_reset", ref_out(P_IDLE, 0, 0, 0, me));
    run_insn("set", 9'b00_10_00111, 1'b0, 0);
    run_insn("br_taken", 9'b01_0_1_11110, 1'b1, 0);
    run_insn("br_not", 9'b01_0_1_11110, 1'b0, 0);
    run_insn("jmp_abs", 9'b01_1_0_10101, 1'b0, 0);
    run_insn("jmp_rel", 9'b01_1_1_10000, 1'b0, 0);
    run_insn("alu_add", 9'b10_00_01_001, 1'b0, 0);
    run_insn("cmp", 9'b10_01_10_110, 1'b1, 0);
    run_insn("nop", 9'b11_0000000, 1'b1, 0);
    idle_hold();
    run_insn("load", 9'b10_01_10_011, 1'b0, 2);
    run_insn("load_fast", 9'b10_11_00_011, 1'b0, 0);
    run_insn("sv_last", 9'b10_11_00_100, 1'b0, 14);
    run_insn("sv_timeout", 9'b10_11_00_100, 1'b0, 99);
    run_insn("ld_timeout", 9'b10_00_11_011, 1'b0, 99);
    run_insn("sticky", 9'b00_01_11111, 1'b0, 0);
    for (int i = 0; i < 40; i++) begin
      int r = $urandom_range(0, 9);
      int insn = r < 4 ? 256 + $urandom_range(0, 15) * 8 + (r < 2 ? 3 : 4) : $urandom_range(0, 510);
      run_insn("rand", insn, 1'($urandom), $urandom_range(0, 16));
      if ($urandom_range(0, 3) == 0) idle_hold();
    end
    run_insn("sv_timeout2", 9'b10_10_01_100, 1'b0, 99);
    _instruction = 9'b10_01_01_100;
    insnValid = 1'b1;
    tick();
    insnValid = 1'b0;
    tick();
    #1 check("mid_wait", ref_out(P_WAIT, 9'b10_01_01_100, 0, 0, me));
    #1 reset = 1'b1;
    #1 check("async_reset", ref_out(P_RST, 0, 0, 0, 0));
    tick();
    reset = 1'b0;
    me = 1'b0;
    #1 check("after_async", ref_out(P_IDLE, 0, 0, 0, me));
    run_insn("first_after_rst", 9'b10_10_11_000, 1'b0, 0);
    run_insn("halt", 511, 1'b0, 0);
    do_reset();
    run_insn("post_halt", 9'b00_11_10101, 1'b0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
